// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, legal format bounds,
// and the idle line level.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP   = 3'd4;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: wraps at CLKS_PER_BIT-1 and strobes bit_end
// on that count; held at zero while clear is high.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_end = !clear && (count == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// Parametrised UART transmitter (start, data LSB first, stop bits).
// Optional parity bit is compiled in with macro UART_TX_PARITY_EN.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [2:0]           current_state
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_bad_cfg
    $error("uart_tx_engine: illegal parameter set");
  end

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic                 bit_end;
  logic                 timer_clear;

  assign timer_clear = (state == S_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (state == S_IDLE && tx_valid) begin
      parity <= (^tx_data) ^ 1'(PARITY_ODD);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      tx_serial <= IDLE_LEVEL;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shreg     <= tx_data;
            tx_serial <= ~IDLE_LEVEL;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_serial <= shreg[0];
            bit_idx   <= '0;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_serial <= parity;
              state     <= S_PARITY;
`else
              tx_serial <= IDLE_LEVEL;
              stop_cnt  <= 1'b0;
              state     <= S_STOP;
`endif
            end else begin
              // next bit is already at position 1 before the shift lands
              tx_serial <= shreg[1];
              bit_idx   <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            tx_serial <= IDLE_LEVEL;
            stop_cnt  <= 1'b0;
            state     <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (stop_cnt == LAST_STOP) begin
              tx_done <= 1'b1;
              state   <= S_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx_serial <= IDLE_LEVEL;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready      = (state == S_IDLE);
  assign tx_busy       = (state != S_IDLE);
  assign current_state = state;

endmodule
